// File: rtl/udp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : udp_arb_pkg
// Purpose  : Shared constants and types for the UDP TX arbiter.
//            - BYTE_W             : width of one MII-side data byte
//            - IFG_CYCLES_DEFAULT : default inter-frame gap in clk cycles
//                                   (96 bit times at 4 bits per cycle)
//            - arb_state_t        : arbiter FSM state encoding
// Revision : 1.0 - initial release
// ============================================================================
package udp_arb_pkg;

  localparam int BYTE_W             = 8;
  localparam int IFG_CYCLES_DEFAULT = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_IFG   = 2'd2
  } arb_state_t;

endpackage : udp_arb_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational winner selection for the UDP TX arbiter.
//            Default build: round robin, the search starts at (last+1) mod
//            NUM_REQ and wraps upward.
//            With UDP_ARB_FIXED_PRIO_EN defined: fixed priority, the lowest
//            eligible index wins and `last` is ignored.
// Ports    : eligible [NUM_REQ]   - requesters allowed to win this cycle
//            last     [IDX_W]     - index of the previous frame owner
//            winner   [NUM_REQ]   - one-hot winner, 0 when nothing eligible
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] winner
);

`ifdef UDP_ARB_FIXED_PRIO_EN
  // Pointer is not part of the fixed-priority scheme.
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    logic found;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && eligible[i]) begin
        winner[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end
`else
  always_comb begin
    logic found;
    int   idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    // Visit last+1, last+2, ... wrapping; last itself is visited last so the
    // previous owner only wins again when nobody else is eligible.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!found && eligible[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end
`endif

endmodule : rr_pick
`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : udp_tx_arbiter
// Purpose  : Packet-granular arbiter sharing one MII byte-stream transmitter
//            between NUM_REQ UDP frame sources. The grant is locked for a
//            whole frame and IFG_CYCLES idle cycles are inserted after each
//            frame before the next grant.
// Config   : UDP_ARB_FIXED_PRIO_EN - when defined, lowest index wins instead
//            of round robin and the round-robin pointer is not built.
// Ports    : clk, reset             - MII clock, synchronous active-high reset
//            req_data/valid/start/last, req_ready - per-requester byte streams
//            tx_data/valid/start, tx_ready        - stream to the MII TX block
//            grant      - one-hot current owner (0 when none)
//            busy       - high while a frame or inter-frame gap is in progress
//            proto_err  - registered one-cycle pulse per protocol violation
//                         (appears the cycle after the offending byte)
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_arbiter
  import udp_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int IFG_CYCLES = IFG_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*BYTE_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_start,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_valid,
  output logic                      tx_start,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      proto_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // Counter only ever holds IFG_CYCLES-1 down to 0.
  localparam int CNT_W = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               first_q, first_d;
  logic [CNT_W-1:0]   ifg_cnt_q, ifg_cnt_d;
  logic               busy_q, busy_d;
  logic               proto_err_q, proto_err_d;
  logic [IDX_W-1:0]   pick_last;
  logic [NUM_REQ-1:0] winner;
  logic               own_start;
  logic               own_last;
  logic               accept;

`ifndef UDP_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_idx;
  assign pick_last = last_q;
`else
  assign pick_last = '0;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .eligible (req_valid & req_start),
    .last     (pick_last),
    .winner   (winner)
  );

  // Owner mux. Everything is gated by reset so no byte is handed over in the
  // cycle that abandons a frame.
  always_comb begin
    tx_data   = '0;
    tx_valid  = 1'b0;
    tx_start  = 1'b0;
    req_ready = '0;
    own_start = 1'b0;
    own_last  = 1'b0;
`ifndef UDP_ARB_FIXED_PRIO_EN
    owner_idx = '0;
`endif
    if (state_q == ST_GRANT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_q[i]) begin
          tx_data      = req_data[i*BYTE_W +: BYTE_W];
          tx_valid     = req_valid[i] & ~reset;
          tx_start     = req_valid[i] & ~reset & first_q & req_start[i];
          req_ready[i] = tx_ready & ~reset;
          own_start    = req_start[i];
          own_last     = req_last[i];
`ifndef UDP_ARB_FIXED_PRIO_EN
          owner_idx    = IDX_W'(i);
`endif
        end
      end
    end
  end

  assign accept = tx_valid & tx_ready;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    first_d     = first_q;
    ifg_cnt_d   = ifg_cnt_q;
    proto_err_d = 1'b0;
`ifndef UDP_ARB_FIXED_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Valid without start while idle is a stream with no frame header.
        proto_err_d = |(req_valid & ~req_start);
        if (|winner) begin
          grant_d = winner;
          first_d = 1'b1;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          first_d = 1'b0;
          // Start marker inside a frame is forwarded but flagged.
          if (!first_q && own_start) begin
            proto_err_d = 1'b1;
          end
          if (own_last) begin
            grant_d = '0;
`ifndef UDP_ARB_FIXED_PRIO_EN
            last_d  = owner_idx;
`endif
            if (IFG_CYCLES == 0) begin
              state_d = ST_IDLE;
            end else begin
              ifg_cnt_d = CNT_W'(IFG_CYCLES - 1);
              state_d   = ST_IFG;
            end
          end
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      first_q     <= 1'b0;
      ifg_cnt_q   <= '0;
      busy_q      <= 1'b0;
      proto_err_q <= 1'b0;
`ifndef UDP_ARB_FIXED_PRIO_EN
      // Pointing at the top index makes requester 0 the first winner.
      last_q      <= IDX_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      ifg_cnt_q   <= ifg_cnt_d;
      busy_q      <= busy_d;
      proto_err_q <= proto_err_d;
`ifndef UDP_ARB_FIXED_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign proto_err = proto_err_q;

endmodule : udp_tx_arbiter
`default_nettype wire

// File: tb/tb_udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx_arbiter
// Purpose  : Directed self-checking bench for udp_tx_arbiter. Main instance
//            uses NUM_REQ=2, IFG_CYCLES=24; a second instance uses
//            IFG_CYCLES=0. Inputs change at the falling edge, outputs are
//            sampled 1 time unit later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] req_data;
  logic [1:0]  req_valid, req_start, req_last, req_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_start, tx_ready;
  logic [1:0]  grant;
  logic        busy, proto_err;

  logic [15:0] d0_req_data;
  logic [1:0]  d0_req_valid, d0_req_start, d0_req_last, d0_req_ready;
  logic [7:0]  d0_tx_data;
  logic        d0_tx_valid, d0_tx_start, d0_tx_ready;
  logic [1:0]  d0_grant;
  logic        d0_busy, d0_proto_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  udp_tx_arbiter #(.NUM_REQ(2), .IFG_CYCLES(24)) u_dut (
    .clk(clk), .reset(reset),
    .req_data(req_data), .req_valid(req_valid), .req_start(req_start),
    .req_last(req_last), .req_ready(req_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_start(tx_start),
    .tx_ready(tx_ready), .grant(grant), .busy(busy), .proto_err(proto_err)
  );

  udp_tx_arbiter #(.NUM_REQ(2), .IFG_CYCLES(0)) u_dut_ifg0 (
    .clk(clk), .reset(reset),
    .req_data(d0_req_data), .req_valid(d0_req_valid), .req_start(d0_req_start),
    .req_last(d0_req_last), .req_ready(d0_req_ready),
    .tx_data(d0_tx_data), .tx_valid(d0_tx_valid), .tx_start(d0_tx_start),
    .tx_ready(d0_tx_ready), .grant(d0_grant), .busy(d0_busy),
    .proto_err(d0_proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 60 && busy; c++) begin
      @(negedge clk); #1;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc [2];
    int acc0, acc1, own, nfr, last_cyc, k;
    int winners [4];
    bit done;

    reset = 1'b1; req_data = '0; req_valid = '0; req_start = '0; req_last = '0;
    tx_ready = 1'b1;
    d0_req_data = '0; d0_req_valid = '0; d0_req_start = '0; d0_req_last = '0;
    d0_tx_ready = 1'b1;

    // ---------------- reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_perr",  32'(proto_err), 32'd0);
    chk("rst_txv",   32'(tx_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    @(negedge clk); reset = 1'b0;

    // ---------------- T1: req0 4-byte frame, then 24-cycle gap
    @(negedge clk);
    req_valid = 2'b01; req_start = 2'b01; req_data[7:0] = 8'hA0; #1;
    chk("t1_req_cycle_grant", 32'(grant), 32'd0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      req_start = (b == 0) ? 2'b01 : 2'b00;
      req_last  = (b == 3) ? 2'b01 : 2'b00;
      req_data[7:0] = 8'hA0 + 8'(b);
      #1;
      chk("t1_grant", 32'(grant), 32'd1);
      chk("t1_data",  32'(tx_data), 32'(8'hA0 + 8'(b)));
      chk("t1_start", 32'(tx_start), (b == 0) ? 32'd1 : 32'd0);
      chk("t1_ready", 32'(req_ready), 32'd1);
    end
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) begin req_valid = '0; req_start = '0; req_last = '0; end
      #1;
      chk("t1_ifg", 32'({grant, busy, tx_valid}), 32'b0010);
    end
    @(negedge clk); #1;
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // ---------------- T2: req0 and req1 continuously, 3-byte frames
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    bc[0] = 0; bc[1] = 0; acc0 = 0; acc1 = 0; own = 0; nfr = 0;
    last_cyc = -1; done = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk);
      if (acc0 != 0) bc[0] = (bc[0] == 2) ? 0 : bc[0] + 1;
      if (acc1 != 0) bc[1] = (bc[1] == 2) ? 0 : bc[1] + 1;
      req_valid = 2'b11;
      req_start = {bc[1] == 0, bc[0] == 0};
      req_last  = {bc[1] == 2, bc[0] == 2};
      req_data  = {4'h1, 4'(bc[1]), 4'h0, 4'(bc[0])};
      #1;
      acc0 = int'(req_ready[0] & req_valid[0]);
      acc1 = int'(req_ready[1] & req_valid[1]);
      if (tx_valid && tx_ready) begin
        if (tx_start) begin
          // 24 IFG cycles plus the one IDLE cycle spent arbitrating.
          if (last_cyc >= 0) chk("t2_gap", 32'(cyc - last_cyc - 1), 32'd25);
          own = (grant == 2'b10) ? 1 : 0;
          winners[nfr] = own;
        end
        chk("t2_data", 32'(tx_data),
            (own == 1) ? 32'({4'h1, 4'(bc[1])}) : 32'({4'h0, 4'(bc[0])}));
        if (req_last[own]) begin
          last_cyc = cyc;
          nfr++;
          if (nfr == 4) done = 1'b1;
        end
      end
    end
    @(negedge clk); req_valid = '0; req_start = '0; req_last = '0; #1;
    chk("t2_frames", 32'(nfr), 32'd4);
`ifdef UDP_ARB_FIXED_PRIO_EN
    chk("t2_order0", 32'(winners[0]), 32'd0);
    chk("t2_order1", 32'(winners[1]), 32'd0);
    chk("t2_order2", 32'(winners[2]), 32'd0);
    chk("t2_order3", 32'(winners[3]), 32'd0);
`else
    chk("t2_order0", 32'(winners[0]), 32'd0);
    chk("t2_order1", 32'(winners[1]), 32'd1);
    chk("t2_order2", 32'(winners[2]), 32'd0);
    chk("t2_order3", 32'(winners[3]), 32'd1);
`endif
    wait_idle("t2_idle");

    // ---------------- T3: req1 6-byte frame with tx_ready toggling
    @(negedge clk);
    req_valid = 2'b10; req_start = 2'b10; req_last = '0; req_data = 16'h1000; #1;
    chk("t3_req_cycle_grant", 32'(grant), 32'd0);
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
      @(negedge clk);
      tx_ready  = (cyc % 2 == 0);
      req_start = {k == 0, 1'b0};
      req_last  = {k == 5, 1'b0};
      req_data[15:8] = 8'h10 + 8'(k);
      #1;
      chk("t3_ready", 32'(req_ready), 32'({tx_ready, 1'b0}));
      if (tx_ready) begin
        chk("t3_data",  32'(tx_data), 32'(8'h10 + 8'(k)));
        chk("t3_start", 32'(tx_start), (k == 0) ? 32'd1 : 32'd0);
        k++;
      end
    end
    chk("t3_count", 32'(k), 32'd6);
    @(negedge clk); req_valid = '0; req_start = '0; req_last = '0; tx_ready = 1'b1; #1;
    chk("t3_ifg", 32'({grant, req_ready, busy}), 32'b00001);
    wait_idle("t3_idle");

    // ---------------- T4: protocol errors
    @(negedge clk); req_valid = 2'b10; req_start = 2'b00; #1;
    chk("t4_noready", 32'(req_ready), 32'd0);
    chk("t4_perr_pre", 32'(proto_err), 32'd0);
    @(negedge clk); #1;
    chk("t4_perr_a", 32'(proto_err), 32'd1);
    chk("t4_nogrant", 32'(grant), 32'd0);
    @(negedge clk); req_valid = '0; #1;
    chk("t4_perr_b", 32'(proto_err), 32'd1);
    @(negedge clk); #1;
    chk("t4_perr_end", 32'(proto_err), 32'd0);
    chk("t4_idle", 32'({grant, busy}), 32'd0);
    @(negedge clk); req_valid = 2'b01; req_start = 2'b01; req_data = 16'h00B0; #1;
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      req_start = (b == 0 || b == 3) ? 2'b01 : 2'b00;
      req_last  = (b == 4) ? 2'b01 : 2'b00;
      req_data[7:0] = 8'hB0 + 8'(b);
      #1;
      chk("t4_tx_start", 32'(tx_start), (b == 0) ? 32'd1 : 32'd0);
      if (b == 1) chk("t4_perr_first", 32'(proto_err), 32'd0);
      if (b == 4) chk("t4_perr_mid", 32'(proto_err), 32'd1);
    end
    @(negedge clk); req_valid = '0; req_start = '0; req_last = '0; #1;
    chk("t4_perr_single", 32'(proto_err), 32'd0);
    wait_idle("t4_idle");

    // ---------------- T5: reset at byte 2 of a req1 frame
    @(negedge clk); req_valid = 2'b10; req_start = 2'b10; req_data = 16'h2000; #1;
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      req_start = {b == 0, 1'b0};
      req_data[15:8] = 8'h20 + 8'(b);
      if (b == 2) reset = 1'b1;
      #1;
      if (b == 2) begin
        chk("t5_rst_ready", 32'(req_ready), 32'd0);
        chk("t5_rst_txv", 32'(tx_valid), 32'd0);
      end else begin
        chk("t5_grant", 32'(grant), 32'd2);
      end
    end
    @(negedge clk); reset = 1'b0; req_valid = '0; req_start = '0; #1;
    chk("t5_post_rst", 32'({grant, busy, tx_valid}), 32'd0);
    // Pointer is back to its reset value, so req0 beats req1.
    @(negedge clk);
    req_valid = 2'b11; req_start = 2'b11; req_last = 2'b01; req_data = 16'h30C0; #1;
    @(negedge clk); #1;
    chk("t5_winner", 32'(grant), 32'd1);
    chk("t5_single_start", 32'(tx_start), 32'd1);
    chk("t5_single_data", 32'(tx_data), 32'hC0);
    @(negedge clk); req_valid = '0; req_start = '0; req_last = '0; #1;
    chk("t5_single_done", 32'({grant, busy}), 32'b001);
    wait_idle("t5_idle");

    // ---------------- T6: IFG_CYCLES=0, back-to-back single-byte frames
    @(negedge clk);
    d0_req_valid = 2'b01; d0_req_start = 2'b01; d0_req_last = 2'b01; d0_req_data = 16'h0055; #1;
    chk("t6_req_cycle", 32'(d0_grant), 32'd0);
    @(negedge clk); #1;
    chk("t6_grant1", 32'(d0_grant), 32'd1);
    chk("t6_txv1", 32'({d0_tx_valid, d0_tx_start}), 32'b11);
    @(negedge clk); #1;
    chk("t6_between", 32'({d0_grant, d0_busy}), 32'd0);
    @(negedge clk); #1;
    chk("t6_grant2", 32'(d0_grant), 32'd1);
    chk("t6_start2", 32'(d0_tx_start), 32'd1);
    @(negedge clk); d0_req_valid = '0; d0_req_start = '0; d0_req_last = '0; #1;
    chk("t6_end", 32'(d0_grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_udp_tx_arbiter
`default_nettype wire
